wb_burst_master: RTL

WB_BURST_MASTER -- requirements
Module: wb_burst_master

---
 rtl/wb_burst_master.sv | 136 +++++++++++++
 1 files changed

// File: rtl/wb_burst_master.sv
// Wishbone burst master: runs one read or write burst of count_i beats from base_i.
// An ack timeout aborts the burst with an err_o pulse; each beat costs one acked bus cycle.
module wb_burst_master #(
  parameter int WIDTH = 32,
  parameter int ABITS = 12,
  parameter int CBITS = 8,
  parameter int TBITS = 4,
  parameter int DELAY = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             write_i,
  input  logic [ABITS-1:0] base_i,
  input  logic [CBITS-1:0] count_i,
  input  logic [WIDTH-1:0] wr_dat_i,
  output logic             wr_nxt_o,
  output logic [WIDTH-1:0] rd_dat_o,
  output logic             rd_vld_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic             cyc_o,
  output logic             stb_o,
  output logic             we_o,
  output logic             bst_o,
  output logic [ABITS-1:0] adr_o,
  output logic [WIDTH-1:0] dat_o,
  input  logic             ack_i,
  input  logic [WIDTH-1:0] dat_i
);

  typedef enum logic [1:0] {IDLE, BUS, FIN} state_t;

  localparam logic [TBITS-1:0] TMO_LAST = {TBITS{1'b1}} - 1'b1;

  // DELAY only shapes behavioural models; real flops carry no delay.
  logic [31:0] unused_delay;
  assign unused_delay = DELAY;

  state_t             state_q, state_d;
  logic [ABITS-1:0]   adr_q, adr_d;
  logic [CBITS-1:0]   rem_q, rem_d;
  logic [TBITS-1:0]   tmo_q, tmo_d;
  logic               we_q, we_d;
  logic [WIDTH-1:0]   rd_dat_q, rd_dat_d;
  logic               rd_vld_q, rd_vld_d;
  logic               err_q, err_d;

  always_comb begin
    state_d  = state_q;
    adr_d    = adr_q;
    rem_d    = rem_q;
    tmo_d    = tmo_q;
    we_d     = we_q;
    rd_dat_d = rd_dat_q;
    rd_vld_d = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          tmo_d = '0;
          if (count_i != '0) begin
            state_d = BUS;
            adr_d   = base_i;
            rem_d   = count_i;
            we_d    = write_i;
          end else begin
            state_d = FIN;
          end
        end
      end
      BUS: begin
        if (ack_i) begin
          adr_d = adr_q + 1'b1;
          rem_d = rem_q - 1'b1;
          tmo_d = '0;
          if (!we_q) begin
            rd_dat_d = dat_i;
            rd_vld_d = 1'b1;
          end
          if (rem_q == CBITS'(1)) begin
            state_d = FIN;
            we_d    = 1'b0;
          end
        end else begin
          tmo_d = tmo_q + 1'b1;
          // Counter hits all-ones on this cycle: abandon the burst.
          if (tmo_q == TMO_LAST) begin
            state_d = IDLE;
            we_d    = 1'b0;
            err_d   = 1'b1;
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      adr_q    <= '0;
      rem_q    <= '0;
      tmo_q    <= '0;
      we_q     <= 1'b0;
      rd_dat_q <= '0;
      rd_vld_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      adr_q    <= adr_d;
      rem_q    <= rem_d;
      tmo_q    <= tmo_d;
      we_q     <= we_d;
      rd_dat_q <= rd_dat_d;
      rd_vld_q <= rd_vld_d;
      err_q    <= err_d;
    end
  end

  assign busy_o   = (state_q != IDLE);
  assign cyc_o    = (state_q == BUS);
  assign stb_o    = (state_q == BUS);
  assign we_o     = cyc_o && we_q;
  assign bst_o    = cyc_o && (rem_q > CBITS'(1));
  assign adr_o    = adr_q;
  assign dat_o    = we_o ? wr_dat_i : '0;
  assign wr_nxt_o = ack_i && we_o && stb_o;
  assign rd_dat_o = rd_dat_q;
  assign rd_vld_o = rd_vld_q;
  assign done_o   = (state_q == FIN);
  assign err_o    = err_q;

endmodule
